array_mult_sequencer: RTL and testbench



---
 rtl/array_mult_sequencer.sv | 125 ++++++++++++
 tb/tb_array_mult_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_mult_sequencer.sv
// Sequencer that forms a 2*HALF x 2*HALF unsigned product by stepping one shared
// HALF x HALF array multiplier through four partial products and accumulating them.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high, multiplier inputs parked at 0
//   MUL   | step 0..3 drives one nibble pair to the multiplier and accumulates mul_p
//   DONE  | product presented on result with out_valid until out_ready
module array_mult_sequencer #(
    parameter int HALF = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF-1:0]   in_a,
    input  logic [2*HALF-1:0]   in_b,
    output logic [HALF-1:0]     mul_a,
    output logic [HALF-1:0]     mul_b,
    input  logic [2*HALF-1:0]   mul_p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*HALF-1:0]   result,
    output logic [7:0]          op_count
);

    localparam int W  = 2 * HALF;
    localparam int PW = 4 * HALF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      step;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   partial;
    logic [PW-1:0]   partial_shifted;

    // Weight of each partial product: lo*lo x1, cross terms x2^HALF, hi*hi x2^(2*HALF).
    always_comb begin
        partial         = {{(PW - W){1'b0}}, mul_p};
        partial_shifted = partial;
        case (step)
            2'd0:    partial_shifted = partial;
            2'd1:    partial_shifted = partial << HALF;
            2'd2:    partial_shifted = partial << HALF;
            default: partial_shifted = partial << W;
        endcase
        acc_next = acc + partial_shifted;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                mul_a = step[0] ? a_reg[W-1:HALF] : a_reg[HALF-1:0];
                mul_b = step[1] ? b_reg[W-1:HALF] : b_reg[HALF-1:0];
                if (step == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step     <= 2'd0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            result   <= '0;
            op_count <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        acc   <= '0;
                        step  <= 2'd0;
                    end
                end
                MUL: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        result <= acc_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        op_count <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_array_mult_sequencer.sv
// Self-checking bench: an abstract cycle model (accept, four compute cycles, hold until
// taken) checks every output each cycle; directed cases pin the model with literal values.
module tb_array_mult_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [7:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;

    array_mult_sequencer #(.HALF(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .op_count  (op_count)
    );

    // Shared combinational array multiplier outside the block.
    assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 waiting, 1..4 computing partial k=phase-1, 5 result held.
    int phase      = 0;
    int cnt        = 0;
    int ea         = 0;
    int eb         = 0;
    int exp_prod   = 0;
    bit model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            phase      = 0;
            cnt        = 0;
            model_live = 1;
        end else if (model_live) begin
            if (phase == 0) begin
                if (in_valid) begin
                    ea       = int'(in_a);
                    eb       = int'(in_b);
                    exp_prod = ea * eb;
                    phase    = 1;
                end
            end else if (phase < 5) begin
                phase = phase + 1;
            end else if (out_ready) begin
                cnt   = (cnt + 1) % 256;
                phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("in_ready", 32'(in_ready), 32'(phase == 0));
            chk("out_valid", 32'(out_valid), 32'(phase == 5));
            chk("op_count", 32'(op_count), cnt);
            if (phase == 5) chk("result", 32'(result), exp_prod);
            if (phase == 0) begin
                chk("mul_a_idle", 32'(mul_a), 0);
                chk("mul_b_idle", 32'(mul_b), 0);
            end else if (phase <= 4) begin
                chk("mul_a", 32'(mul_a), ((phase - 1) % 2 == 1) ? ea / 16 : ea % 16);
                chk("mul_b", 32'(mul_b), ((phase - 1) / 2 == 1) ? eb / 16 : eb % 16);
            end
        end
    end

    int exp_ops = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ops = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(in_ready), 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_res,
                          input bit chk_mul, input logic [15:0] seq_a, input logic [15:0] seq_b);
        int n;
        wait_ready();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        tick();
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            if (chk_mul && n < 4) begin
                chk("mul_a_seq", 32'(mul_a), 32'(seq_a[4*n +: 4]));
                chk("mul_b_seq", 32'(mul_b), 32'(seq_b[4*n +: 4]));
            end
            tick();
            n++;
        end
        chk("latency", n, 4);
        chk("result_literal", 32'(result), 32'(exp_res));
        chk("model_literal", exp_prod, 32'(exp_res));
        tick();
        exp_ops = (exp_ops + 1) % 256;
        chk("op_count_after", 32'(op_count), exp_ops);
        chk("idle_after", 32'(in_ready), 1);
    endtask

    initial begin
        int n;
        int nout;
        int last;
        int cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);

        run_op(8'h0F, 8'h0F, 16'h00E1, 1'b0, 16'h0, 16'h0);
        chk("op_count_first", 32'(op_count), 1);
        run_op(8'hA5, 8'h3C, 16'h26AC, 1'b1, 16'hA5A5, 16'h33CC);
        run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, 16'h0, 16'h0);
        run_op(8'h00, 8'hB7, 16'h0000, 1'b0, 16'h0, 16'h0);

        // Back-pressure while new operands are offered.
        wait_ready();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h12;
        in_b      = 8'h34;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_latency", n, 4);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            tick();
            chk("bp_result", 32'(result), 32'h03A8);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_op_count", 32'(op_count), exp_ops);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        exp_ops = (exp_ops + 1) % 256;
        chk("bp_release_idle", 32'(in_ready), 1);
        chk("bp_release_count", 32'(op_count), exp_ops);

        // Abort an operation with reset during step 2.
        do_reset();
        wait_ready();
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_op_count", 32'(op_count), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_valid", 32'(out_valid), 0);
        end
        run_op(8'h02, 8'h03, 16'h0006, 1'b0, 16'h0, 16'h0);

        // Random handshakes, checked every cycle by the model.
        for (int i = 0; i < 800; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_ready();

        // Back-to-back throughput and op_count wrap.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nout = 0;
        last = 0;
        cyc  = 0;
        while (nout < 256 && cyc < 3000) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            tick();
            cyc++;
            if (out_valid) begin
                if (nout > 0) chk("issue_interval", cyc - last, 6);
                last = cyc;
                nout++;
            end
        end
        chk("tput_count", nout, 256);
        chk("pre_wrap_count", 32'(op_count), 255);
        in_valid = 1'b0;
        tick();
        chk("wrap_count", 32'(op_count), 0);
        chk("wrap_idle", 32'(in_ready), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
